debug_host_link: RTL and testbench

- Host-side initiator for the pipeline debug protocol carried over UART.
- Issues the single-byte commands 'c' (continuous), 's' (step) and 'n' (next) into the UART TX FIFO.
- Drains the UART RX FIFO and assembles each returned 95-byte pipeline-state frame into a local buffer, then flags the frame complete.
- Sits between a user or test controller and a UART core. Used for board-to-board loopback and hardware self-test of the debug path.

---
 rtl/debug_proto_pkg.sv | 42 ++++
 rtl/debug_frame_buffer.sv | 23 ++
 rtl/debug_host_link.sv | 179 +++++++++++++++++
 tb/tb_debug_host_link.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_proto_pkg.sv
// Shared constants, frame layout and host state encoding for the UART pipeline
// debug protocol.
package debug_proto_pkg;

   localparam logic [7:0] CMD_CONT = 8'h63;
   localparam logic [7:0] CMD_STEP = 8'h73;
   localparam logic [7:0] CMD_NEXT = 8'h6E;

   localparam int unsigned FRAME_BYTES = 95;
   localparam int unsigned BUF_DEPTH   = 128;
   localparam logic [6:0]  LAST_IDX    = 7'(FRAME_BYTES - 1);

   localparam logic [6:0] OFS_PC           = 7'd0;
   localparam logic [6:0] OFS_INSTR        = 7'd1;
   localparam logic [6:0] OFS_PCNEXT       = 7'd5;
   localparam logic [6:0] OFS_ALUOP        = 7'd6;
   localparam logic [6:0] OFS_SIGEXT       = 7'd7;
   localparam logic [6:0] OFS_RD1          = 7'd11;
   localparam logic [6:0] OFS_RD2          = 7'd15;
   localparam logic [6:0] OFS_EXMEM_WREG   = 7'd31;
   localparam logic [6:0] OFS_MEMWB_MEMOUT = 7'd49;

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StSendCont  = 3'd1,
      StRecvCont  = 3'd2,
      StSendStep  = 3'd3,
      StStepArmed = 3'd4,
      StSendNext  = 3'd5,
      StRecvStep  = 3'd6
   } host_state_e;

   function automatic logic [7:0] send_cmd(host_state_e s);
      case (s)
         StSendCont: send_cmd = CMD_CONT;
         StSendStep: send_cmd = CMD_STEP;
         StSendNext: send_cmd = CMD_NEXT;
         default:    send_cmd = 8'h00;
      endcase
   endfunction

endpackage

// File: rtl/debug_frame_buffer.sv
// 128x8 frame store: one synchronous write port, one asynchronous read port.
module debug_frame_buffer
   import debug_proto_pkg::*;
(
   input  logic       clock,
   input  logic       we,
   input  logic [6:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic [6:0] rd_addr,
   output logic [7:0] rd_data
);

   logic [7:0] mem [BUF_DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/debug_host_link.sv
// Host-side debug link: sends c/s/n commands to the UART TX FIFO and assembles
// returned pipeline-state frames from the RX FIFO.
module debug_host_link #(
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        startCont,
   input  logic        startStep,
   input  logic        stepNext,
   input  logic        stop,
   input  logic [7:0]  rxData,
   input  logic        rxDataAvailable,
   output logic        rxReadFlag,
   output logic [7:0]  txData,
   output logic        txWriteFlag,
   input  logic        txFull,
   input  logic [6:0]  bufAddr,
   output logic [7:0]  bufData,
   output logic [7:0]  framePc,
   output logic [31:0] frameInstr,
   output logic        frameValid,
   output logic [15:0] frameCount,
   output logic [7:0]  dropCount,
   output logic        timeoutErr,
   output logic        busy,
   output logic        stepMode
);
   import debug_proto_pkg::*;

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   host_state_e state_q, state_d;
   logic [6:0]  wr_ptr_q, wr_ptr_d;
   logic        valid_q, valid_d;
   logic [15:0] count_q, count_d;
   logic [7:0]  drop_q, drop_d;
   logic        err_q, err_d;
   logic [31:0] idle_q, idle_d;
   logic [7:0]  pc_q, pc_d;
   logic [31:0] instr_q, instr_d;

   logic        rx_pop;
   logic        buf_we;
   logic        tx_push;
   logic [7:0]  tx_byte;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         wr_ptr_q <= 7'd0;
         valid_q  <= 1'b0;
         count_q  <= 16'd0;
         drop_q   <= 8'd0;
         err_q    <= 1'b0;
         idle_q   <= 32'd0;
         pc_q     <= 8'd0;
         instr_q  <= 32'd0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         valid_q  <= valid_d;
         count_q  <= count_d;
         drop_q   <= drop_d;
         err_q    <= err_d;
         idle_q   <= idle_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      valid_d  = valid_q;
      count_d  = count_q;
      drop_d   = drop_q;
      err_d    = err_q;
      idle_d   = idle_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      rx_pop   = 1'b0;
      buf_we   = 1'b0;
      tx_push  = 1'b0;
      tx_byte  = 8'h00;

      unique case (state_q)
         StIdle, StStepArmed: begin
            // Anything arriving outside a receive window is popped and discarded.
            rx_pop = rxDataAvailable;
            if (rxDataAvailable && drop_q != 8'hFF) begin
               drop_d = drop_q + 8'd1;
            end
            if (state_q == StIdle) begin
               if (startCont) begin
                  state_d = StSendCont;
               end else if (startStep) begin
                  state_d = StSendStep;
               end
            end else if (stop) begin
               state_d = StIdle;
            end else if (stepNext) begin
               state_d = StSendNext;
            end
         end

         StSendCont, StSendStep, StSendNext: begin
            tx_byte = send_cmd(state_q);
            if (!txFull) begin
               tx_push  = 1'b1;
               valid_d  = 1'b0;
               wr_ptr_d = 7'd0;
               idle_d   = 32'd0;
               unique case (state_q)
                  StSendCont: state_d = StRecvCont;
                  StSendStep: state_d = StStepArmed;
                  default:    state_d = StRecvStep;
               endcase
            end
         end

         StRecvCont, StRecvStep: begin
            rx_pop = rxDataAvailable;
            if (rxDataAvailable) begin
               buf_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + 7'd1;
               idle_d   = 32'd0;
               case (wr_ptr_q)
                  OFS_PC:            pc_d           = rxData;
                  OFS_INSTR:         instr_d[7:0]   = rxData;
                  OFS_INSTR + 7'd1:  instr_d[15:8]  = rxData;
                  OFS_INSTR + 7'd2:  instr_d[23:16] = rxData;
                  OFS_INSTR + 7'd3:  instr_d[31:24] = rxData;
                  default: ;
               endcase
               if (wr_ptr_q == LAST_IDX) begin
                  valid_d = 1'b1;
                  count_d = count_q + 16'd1;
                  state_d = (state_q == StRecvCont) ? StIdle : StStepArmed;
               end
            end else if (wr_ptr_q != 7'd0) begin
               // The wait for the first byte is unbounded; only gaps inside a frame time out.
               if (idle_q == TIMEOUT_LAST) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  idle_d = idle_q + 32'd1;
               end
            end
         end

         default: state_d = StIdle;
      endcase
   end

   debug_frame_buffer u_frame_buffer (
      .clock   (clock),
      .we      (buf_we),
      .wr_addr (wr_ptr_q),
      .wr_data (rxData),
      .rd_addr (bufAddr),
      .rd_data (bufData)
   );

   // Gated so the FIFO sees no pop while reset is held.
   assign rxReadFlag  = rx_pop & ~reset;
   assign txData      = tx_byte;
   assign txWriteFlag = tx_push;
   assign framePc     = pc_q;
   assign frameInstr  = instr_q;
   assign frameValid  = valid_q;
   assign frameCount  = count_q;
   assign dropCount   = drop_q;
   assign timeoutErr  = err_q;
   assign busy        = (state_q != StIdle);
   assign stepMode    = (state_q == StStepArmed) || (state_q == StSendNext) ||
                        (state_q == StRecvStep);

endmodule

// File: tb/tb_debug_host_link.sv
// Bench for debug_host_link: FIFO emulation, per-cycle comparison against a
// transaction-level model, and directed scenarios with literal expectations.
module tb_debug_host_link;

   localparam int TIMEOUT = 100;
   localparam int FRAME   = 95;
   localparam int PIdle = 0, PSend = 1, PArmed = 2, PRecv = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        startCont = 1'b0, startStep = 1'b0, stepNext = 1'b0, stop = 1'b0;
   logic [7:0]  rxData = 8'h00;
   logic        rxDataAvailable = 1'b0;
   logic        txFull = 1'b0;
   logic [6:0]  bufAddr = 7'd0;
   logic        rxReadFlag, txWriteFlag, frameValid, timeoutErr, busy, stepMode;
   logic [7:0]  txData, bufData, framePc, dropCount;
   logic [31:0] frameInstr;
   logic [15:0] frameCount;

   debug_host_link #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .startCont(startCont), .startStep(startStep),
      .stepNext(stepNext), .stop(stop), .rxData(rxData), .rxDataAvailable(rxDataAvailable),
      .rxReadFlag(rxReadFlag), .txData(txData), .txWriteFlag(txWriteFlag), .txFull(txFull),
      .bufAddr(bufAddr), .bufData(bufData), .framePc(framePc), .frameInstr(frameInstr),
      .frameValid(frameValid), .frameCount(frameCount), .dropCount(dropCount),
      .timeoutErr(timeoutErr), .busy(busy), .stepMode(stepMode)
   );

   always #5 clock = ~clock;

   int tests = 0, fails = 0;
   int cyc = 0;
   int pop_total = 0;
   bit pop_seen = 0;
   logic [7:0] rx_q[$];
   logic [7:0] tx_log[$];

   // Model of the link: what phase the host is in and what the frame outputs must be.
   int          phase = PIdle;
   logic [7:0]  cmd = 8'h00;
   bit          recv_cont = 0;
   int          ptr = 0, idle_run = 0, m_drop = 0;
   logic [15:0] m_count = 16'd0;
   bit          m_valid = 0, m_err = 0;
   logic [7:0]  m_pc = 8'h00;
   logic [31:0] m_instr = 32'h0;
   logic [7:0]  m_mem[128];
   bit          m_known[128];

   task automatic model_reset();
      phase = PIdle; cmd = 8'h00; recv_cont = 0; ptr = 0; idle_run = 0; m_drop = 0;
      m_count = 16'd0; m_valid = 0; m_err = 0; m_pc = 8'h00; m_instr = 32'h0;
      for (int i = 0; i < 128; i++) m_known[i] = 0;
   endtask

   task automatic model_step();
      if (phase == PIdle || phase == PArmed) begin
         if (rxDataAvailable) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
         if (phase == PIdle) begin
            if (startCont) begin phase = PSend; cmd = 8'h63; end
            else if (startStep) begin phase = PSend; cmd = 8'h73; end
         end else if (stop) phase = PIdle;
         else if (stepNext) begin phase = PSend; cmd = 8'h6E; end
      end else if (phase == PSend) begin
         if (!txFull) begin
            m_valid = 0; ptr = 0; idle_run = 0;
            recv_cont = (cmd == 8'h63);
            phase = (cmd == 8'h73) ? PArmed : PRecv;
         end
      end else begin
         if (rxDataAvailable) begin
            m_mem[ptr] = rxData; m_known[ptr] = 1;
            if (ptr == 0) m_pc = rxData;
            if (ptr >= 1 && ptr <= 4) m_instr[8*(ptr-1) +: 8] = rxData;
            ptr++; idle_run = 0;
            if (ptr == FRAME) begin
               m_valid = 1; m_count = m_count + 16'd1;
               phase = recv_cont ? PIdle : PArmed;
            end
         end else if (ptr > 0) begin
            idle_run++;
            if (idle_run == TIMEOUT) begin m_err = 1; phase = PIdle; end
         end
      end
   endtask

   initial forever begin
      @(posedge clock or posedge reset);
      if (reset) model_reset();
      else model_step();
   end

   initial forever begin
      @(posedge clock);
      cyc = cyc + 1;
   end

   task automatic compare_cycle();
      logic [85:0] got, want;
      bit e_rx, e_tw, e_step, known;
      e_rx   = !reset && phase != PSend && rxDataAvailable;
      e_tw   = !reset && phase == PSend && !txFull;
      e_step = (phase == PArmed) || (phase == PSend && cmd == 8'h6E) ||
               (phase == PRecv && !recv_cont);
      known  = m_known[bufAddr];
      got  = {rxReadFlag, txWriteFlag, e_tw ? txData : 8'h00, busy, stepMode, frameValid,
              timeoutErr, dropCount, frameCount, framePc, frameInstr,
              known ? bufData : 8'h00};
      want = {e_rx, e_tw, e_tw ? cmd : 8'h00, phase != PIdle, e_step, m_valid, m_err,
              8'(m_drop), m_count, m_pc, m_instr, known ? m_mem[bufAddr] : 8'h00};
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL cycle_outputs cyc=%0d got=%h want=%h", cyc, got, want);
      end
   endtask

   initial forever begin
      @(negedge clock);
      if (rxReadFlag === 1'b1) begin pop_seen = 1; pop_total++; end
      if (txWriteFlag === 1'b1) tx_log.push_back(txData);
      compare_cycle();
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic drive_rx();
      rxDataAvailable = (rx_q.size() != 0);
      rxData = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
   endtask

   task automatic tick();
      @(posedge clock); #1;
      startCont = 0; startStep = 0; stepNext = 0; stop = 0;
      if (pop_seen && rx_q.size() != 0) void'(rx_q.pop_front());
      pop_seen = 0;
      bufAddr = 7'($urandom_range(0, 127));
      drive_rx();
   endtask

   task automatic push_bytes(input int n, input bit seq);
      for (int i = 0; i < n; i++) rx_q.push_back(seq ? 8'(i) : 8'($urandom));
      drive_rx();
   endtask

   task automatic wait_rx_empty(input string name, input int max);
      int n = 0;
      while (rx_q.size() != 0 && n < max) begin tick(); n++; end
      check(name, 32'(n < max), 32'd1);
   endtask

   task automatic wait_tx(input string name, input int cnt);
      int n = 0;
      while (tx_log.size() < cnt && n < 50) begin tick(); n++; end
      check(name, 32'(n < 50), 32'd1);
   endtask

   initial begin
      int base, cap_cyc, rise, n;
      #1 reset = 1;
      repeat (3) @(posedge clock);
      #1 reset = 0;
      check("reset_count", 32'(frameCount), 32'd0);
      check("reset_valid", 32'(frameValid), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);

      // Continuous run with an ascending frame.
      base = pop_total;
      startCont = 1; tick();
      wait_tx("cont_tx_wait", 1);
      push_bytes(FRAME, 1);
      wait_rx_empty("cont_rx_wait", 300);
      tick();
      check("cont_tx_count", 32'(tx_log.size()), 32'd1);
      check("cont_tx_byte", 32'(tx_log[0]), 32'h63);
      check("cont_pops", 32'(pop_total - base), 32'd95);
      check("cont_valid", 32'(frameValid), 32'd1);
      check("cont_pc", 32'(framePc), 32'h00);
      check("cont_instr", frameInstr, 32'h04030201);
      check("cont_count", 32'(frameCount), 32'd1);
      check("cont_idle", 32'(busy), 32'd0);

      // Step mode with TX back-pressure on the 'n' command.
      startStep = 1; tick();
      wait_tx("step_tx_wait", 2);
      txFull = 1; stepNext = 1; tick();
      repeat (10) tick();
      check("next_held", 32'(tx_log.size()), 32'd2);
      txFull = 0;
      wait_tx("next_tx_wait", 3);
      check("step_tx_byte", 32'(tx_log[1]), 32'h73);
      check("next_tx_byte", 32'(tx_log[2]), 32'h6E);
      push_bytes(FRAME, 0);
      wait_rx_empty("step_rx_wait", 300);
      tick();
      check("step_valid", 32'(frameValid), 32'd1);
      check("step_armed", 32'(stepMode), 32'd1);
      check("step_count", 32'(frameCount), 32'd2);
      stepNext = 1; tick(); tick();
      check("next_drops_valid", 32'(frameValid), 32'd0);
      for (int i = 0; i < FRAME; i++) begin
         push_bytes(1, 0);
         repeat ($urandom_range(0, 3)) tick();
      end
      wait_rx_empty("step2_rx_wait", 400);
      tick();
      check("step2_count", 32'(frameCount), 32'd3);
      stop = 1; tick();
      check("stop_idle", 32'(busy), 32'd0);

      // Stray bytes in IDLE, then an over-long frame.
      push_bytes(3, 0);
      wait_rx_empty("stray_wait", 20);
      check("stray_drop", 32'(dropCount), 32'd3);
      check("stray_valid", 32'(frameValid), 32'd1);
      startCont = 1; tick();
      wait_tx("long_tx_wait", 4);
      push_bytes(FRAME + 2, 0);
      wait_rx_empty("long_rx_wait", 300);
      tick();
      check("long_count", 32'(frameCount), 32'd4);
      check("long_drop", 32'(dropCount), 32'd5);

      // Timeout after 40 bytes.
      startCont = 1; tick();
      wait_tx("to_tx_wait", 5);
      push_bytes(40, 0);
      wait_rx_empty("to_rx_wait", 100);
      cap_cyc = cyc; rise = -1;
      for (int k = 0; k < 300 && rise < 0; k++) begin
         tick();
         if (timeoutErr) rise = cyc;
      end
      check("to_latency", 32'(rise - cap_cyc), 32'd100);
      check("to_valid", 32'(frameValid), 32'd0);
      check("to_idle", 32'(busy), 32'd0);

      // Reset in the middle of a frame.
      startCont = 1; tick();
      wait_tx("rst_tx_wait", 6);
      push_bytes(FRAME, 0);
      base = pop_total; n = 0;
      while (pop_total - base < 50 && n < 200) begin tick(); n++; end
      check("rst_reach50", 32'(n < 200), 32'd1);
      reset = 1; #1;
      check("rst_outputs", {frameCount, dropCount, 2'b00, timeoutErr, frameValid, busy,
                            stepMode, rxReadFlag, txWriteFlag}, 32'd0);
      check("rst_frame", {framePc, frameInstr[23:0]} | {24'd0, frameInstr[31:24]}, 32'd0);
      rx_q.delete(); drive_rx();
      tick(); tick();
      reset = 0;
      tx_log.delete();
      startCont = 1; tick();
      wait_tx("post_tx_wait", 1);
      push_bytes(FRAME, 0);
      wait_rx_empty("post_rx_wait", 300);
      tick();
      check("post_count", 32'(frameCount), 32'd1);
      check("post_valid", 32'(frameValid), 32'd1);

      // Simultaneous pulses.
      startStep = 1; tick();
      wait_tx("sim_step_wait", 2);
      stepNext = 1; stop = 1; tick();
      repeat (3) tick();
      check("stop_wins_idle", 32'(busy), 32'd0);
      check("stop_wins_notx", 32'(tx_log.size()), 32'd2);
      startCont = 1; startStep = 1; tick();
      wait_tx("cont_wins_wait", 3);
      repeat (2) tick();
      check("cont_wins_byte", 32'(tx_log[2]), 32'h63);
      check("cont_wins_once", 32'(tx_log.size()), 32'd3);
      push_bytes(FRAME, 0);
      wait_rx_empty("sim_rx_wait", 300);

      // Random traffic, checked cycle by cycle against the model.
      for (int i = 0; i < 1500; i++) begin
         startCont = ($urandom_range(0, 15) == 0);
         startStep = ($urandom_range(0, 15) == 0);
         stepNext  = ($urandom_range(0, 7) == 0);
         stop      = ($urandom_range(0, 31) == 0);
         txFull    = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 3) != 0) push_bytes(1, 0);
         tick();
      end
      txFull = 0;
      repeat (5) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
